// File: rtl/noc_pkg.sv
// Shared ring-NoC packet field positions, NIC register map and field helpers.
// Packets are 64 bits; the NIC carries them unmodified, so the helpers are for observers only.
package noc_pkg;

   localparam int VC_BIT  = 63;
   localparam int DIR_BIT = 62;
   localparam int HOP_MSB = 55;
   localparam int HOP_LSB = 48;
   localparam int SRC_MSB = 47;
   localparam int SRC_LSB = 32;

   localparam logic [1:0] ADDR_RX_DATA = 2'b00;
   localparam logic [1:0] ADDR_RX_STAT = 2'b01;
   localparam logic [1:0] ADDR_TX_DATA = 2'b10;
   localparam logic [1:0] ADDR_TX_STAT = 2'b11;

   typedef struct packed {
      logic        vc;
      logic        dir;
      logic [5:0]  rsvd;
      logic [7:0]  hop;
      logic [15:0] src;
      logic [31:0] payload;
   } pkt_t;

   function automatic logic pkt_vc(input logic [63:0] p);
      return p[VC_BIT];
   endfunction

   function automatic logic pkt_dir(input logic [63:0] p);
      return p[DIR_BIT];
   endfunction

   function automatic logic [7:0] pkt_hops(input logic [63:0] p);
      return p[HOP_MSB:HOP_LSB];
   endfunction

   function automatic logic [15:0] pkt_src(input logic [63:0] p);
      return p[SRC_MSB:SRC_LSB];
   endfunction

endpackage

// File: rtl/nic_fifo.sv
// Small synchronous FIFO with registered head output; head valid whenever !empty.
// Push when full and pop when empty are ignored; full/empty reflect pre-edge count.
module nic_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         end
         // simultaneous push and pop leaves the occupancy unchanged
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ring_nic.sv
// Processor-side NIC for a ring node: register-mapped TX/RX FIFOs, polarity-gated injection.
// Read data lands in d_out one edge after the strobe; TX waits on net_ro and VC==polarity, RX stalls via net_ri.
module ring_nic
   import noc_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             polarity,
   input  logic [1:0]       addr,
   input  logic             nic_en,
   input  logic             nic_wr_en,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] d_out,
   output logic             net_so,
   input  logic             net_ro,
   output logic [WIDTH-1:0] net_do,
   input  logic             net_si,
   output logic             net_ri,
   input  logic [WIDTH-1:0] net_di
);

   logic [WIDTH-1:0] tx_head;
   logic [WIDTH-1:0] rx_head;
   logic             tx_full;
   logic             tx_empty;
   logic             rx_full;
   logic             rx_empty;
   logic             tx_push;
   logic             rx_pop;
   logic             rx_push;
   logic             rd_vld;
   logic             ri_ok;

   assign tx_push = nic_en && nic_wr_en && (addr == ADDR_TX_DATA);
   assign rd_vld  = nic_en && !nic_wr_en;
   assign rx_pop  = rd_vld && (addr == ADDR_RX_DATA);

   // only the VC matching the current ring phase may enter the router
   assign net_so  = !tx_empty && net_ro && (tx_head[VC_BIT] == polarity);
   assign net_do  = tx_empty ? '0 : tx_head;

   // ri_ok keeps net_ri low through reset and for the release cycle itself
   assign net_ri  = ri_ok && !rx_full;
   assign rx_push = net_si && net_ri;

   nic_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) tx_fifo (
      .clk      (clk),
      .rst_n    (reset),
      .push     (tx_push),
      .push_dat (d_in),
      .pop      (net_so),
      .head     (tx_head),
      .full     (tx_full),
      .empty    (tx_empty)
   );

   nic_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) rx_fifo (
      .clk      (clk),
      .rst_n    (reset),
      .push     (rx_push),
      .push_dat (net_di),
      .pop      (rx_pop),
      .head     (rx_head),
      .full     (rx_full),
      .empty    (rx_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ri_ok <= 1'b0;
      end else begin
         ri_ok <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         d_out <= '0;
      end else if (rd_vld) begin
         case (addr)
            ADDR_RX_DATA: d_out <= rx_empty ? '0 : rx_head;
            ADDR_RX_STAT: d_out <= {{(WIDTH-1){1'b0}}, !rx_empty};
            ADDR_TX_STAT: d_out <= {{(WIDTH-1){1'b0}}, tx_full};
            default:      d_out <= '0;
         endcase
      end
   end

endmodule
